// File: rtl/key_fetch_ctrl_if.sv
// key_fetch_ctrl_if: request/response channel and key-store port bundle.
interface key_fetch_ctrl_if #(
  parameter int WIDTH  = 256,
  parameter int LENGTH = 6
);
  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_lock;
  logic [AW-1:0]     req_slot;
  logic [WIDTH-1:0]  req_wdata;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_err;

  // key-store port
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_valid;

  // per-slot lock bits
  logic [LENGTH-1:0] lock_status;

  // controller side
  modport slave (
    input  req_valid, req_write, req_lock, req_slot, req_wdata,
    input  rsp_ready, mem_rdata, mem_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, lock_status
  );

  // requester / key-store side
  modport master (
    output req_valid, req_write, req_lock, req_slot, req_wdata,
    output rsp_ready, mem_rdata, mem_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, lock_status
  );
endinterface

// File: rtl/key_fetch_ctrl.sv
// key_fetch_ctrl: single-outstanding read/write controller for a slot-based
// key store with sticky per-slot write locks and a read timeout.
// Optional feature macro: KEY_FETCH_ZEROIZE_EN adds zeroize/zeroize_busy and
// a ZERO state that wipes every slot and clears all locks.
module key_fetch_ctrl #(
  parameter int WIDTH  = 256,
  parameter int LENGTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  key_fetch_ctrl_if.slave bus
`ifdef KEY_FETCH_ZEROIZE_EN
  ,
  input  logic            zeroize,
  output logic            zeroize_busy
`endif
);
  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [AW:0] SLOTS = (AW+1)'(LENGTH);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
`ifdef KEY_FETCH_ZEROIZE_EN
    ,
    ZERO
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     slot_reg, slot_next;
  logic              write_reg, write_next;
  logic              lock_reg, lock_next;
  logic [WIDTH-1:0]  wdata_reg, wdata_next;
  logic [WIDTH-1:0]  rsp_data_reg, rsp_data_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [LENGTH-1:0] lock_status_reg, lock_status_next;
  logic [1:0]        tmo_reg, tmo_next;
`ifdef KEY_FETCH_ZEROIZE_EN
  logic              pend_reg, pend_next;
  logic [AW-1:0]     zero_idx_reg, zero_idx_next;
`endif

  // One-hot decodes of the incoming slot and the latched slot.
  logic [LENGTH-1:0] req_hit;
  logic [LENGTH-1:0] slot_hit;
  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_dec
      assign req_hit[gi]  = (bus.req_slot == AW'(gi));
      assign slot_hit[gi] = (slot_reg == AW'(gi));
    end
  endgenerate

  // A request is rejected for an out-of-range slot or a write to a locked slot.
  logic req_oob;
  logic req_bad;
  assign req_oob = ({1'b0, bus.req_slot} >= SLOTS);
  assign req_bad = req_oob || (bus.req_write && (|(req_hit & lock_status_reg)));

  // State and datapath registers; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      slot_reg        <= '0;
      write_reg       <= 1'b0;
      lock_reg        <= 1'b0;
      wdata_reg       <= '0;
      rsp_data_reg    <= '0;
      rsp_err_reg     <= 1'b0;
      lock_status_reg <= '0;
      tmo_reg         <= '0;
`ifdef KEY_FETCH_ZEROIZE_EN
      pend_reg        <= 1'b0;
      zero_idx_reg    <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      write_reg       <= write_next;
      lock_reg        <= lock_next;
      wdata_reg       <= wdata_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_err_reg     <= rsp_err_next;
      lock_status_reg <= lock_status_next;
      tmo_reg         <= tmo_next;
`ifdef KEY_FETCH_ZEROIZE_EN
      pend_reg        <= pend_next;
      zero_idx_reg    <= zero_idx_next;
`endif
    end
  end

  // Next-state logic; response fields only change on the way into RESP so
  // they stay stable for the whole response.
  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    write_next       = write_reg;
    lock_next        = lock_reg;
    wdata_next       = wdata_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_err_next     = rsp_err_reg;
    lock_status_next = lock_status_reg;
    tmo_next         = tmo_reg;
`ifdef KEY_FETCH_ZEROIZE_EN
    pend_next        = pend_reg | zeroize;
    zero_idx_next    = zero_idx_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef KEY_FETCH_ZEROIZE_EN
        if (pend_reg) begin
          state_next    = ZERO;
          zero_idx_next = '0;
        end else
`endif
        if (bus.req_valid) begin
          slot_next  = bus.req_slot;
          write_next = bus.req_write;
          lock_next  = bus.req_lock;
          wdata_next = bus.req_wdata;
          if (req_bad) begin
            rsp_err_next  = 1'b1;
            rsp_data_next = '0;
            state_next    = RESP;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (write_reg) begin
          rsp_err_next  = 1'b0;
          rsp_data_next = '0;
          state_next    = RESP;
          if (lock_reg) begin
            lock_status_next = lock_status_reg | slot_hit;
          end
        end else begin
          tmo_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_valid) begin
          rsp_err_next  = 1'b0;
          rsp_data_next = bus.mem_rdata;
          state_next    = RESP;
        end else if (tmo_reg == 2'd3) begin
          rsp_err_next  = 1'b1;
          rsp_data_next = '0;
          state_next    = RESP;
        end else begin
          tmo_next = tmo_reg + 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
`ifdef KEY_FETCH_ZEROIZE_EN
      ZERO: begin
        if (zero_idx_reg == AW'(LENGTH-1)) begin
          state_next       = IDLE;
          lock_status_next = '0;
          pend_next        = zeroize;
        end else begin
          zero_idx_next = zero_idx_reg + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Key-store strobes: only ACCESS (one strobe) and ZERO drive the bus.
  always_comb begin
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_reg == ACCESS) begin
      bus.mem_addr = slot_reg;
      if (write_reg) begin
        bus.mem_wr_en = 1'b1;
        bus.mem_wdata = wdata_reg;
      end else begin
        bus.mem_rd_en = 1'b1;
      end
    end
`ifdef KEY_FETCH_ZEROIZE_EN
    if (state_reg == ZERO) begin
      bus.mem_wr_en = 1'b1;
      bus.mem_addr  = zero_idx_reg;
    end
`endif
  end

`ifdef KEY_FETCH_ZEROIZE_EN
  assign bus.req_ready  = (state_reg == IDLE) && !pend_reg;
  assign zeroize_busy   = pend_reg || (state_reg == ZERO);
`else
  assign bus.req_ready  = (state_reg == IDLE);
`endif
  assign bus.rsp_valid   = (state_reg == RESP);
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.lock_status = lock_status_reg;

endmodule

// File: tb/tb_key_fetch_ctrl.sv
// tb_key_fetch_ctrl: random + directed requests against a slot/lock model,
// scoreboard queue popped by an independent response monitor.
module tb_key_fetch_ctrl;
  localparam int W  = 256;
  localparam int L  = 6;
  localparam int AW = 3;

  typedef struct {
    logic          write;
    logic [AW-1:0] slot;
    logic [W-1:0]  wdata;
    logic [W-1:0]  data;
    logic          err;
    int            lat;
    int            acc;
    int            rd;
    int            wr;
    logic [L-1:0]  lock;
  } exp_t;

  logic clk;
  logic rst;
  logic mem_dead;
  logic preload;
  logic zmode;
  int   cyc;
  int   total;
  int   bad;
  int   done_cnt;

  logic [W-1:0] model_mem [0:L-1];
  logic [L-1:0] model_lock;
  logic [W-1:0] kmem [0:L-1];
  exp_t         exp_q [$];

  key_fetch_ctrl_if #(.WIDTH(W), .LENGTH(L)) bus ();

`ifdef KEY_FETCH_ZEROIZE_EN
  logic zeroize;
  logic zeroize_busy;
  key_fetch_ctrl #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .rst(rst), .bus(bus), .zeroize(zeroize), .zeroize_busy(zeroize_busy)
  );
`else
  key_fetch_ctrl #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key store: read data returns one cycle after mem_rd_en, unless mem_dead.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < L; i++) kmem[i] <= model_mem[i];
      bus.mem_valid <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_wr_en && (int'(bus.mem_addr) < L)) kmem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_valid <= bus.mem_rd_en && !mem_dead;
      if (bus.mem_rd_en && (int'(bus.mem_addr) < L)) bus.mem_rdata <= kmem[bus.mem_addr];
      else bus.mem_rdata <= {8{$urandom}};
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: rejection rules, sticky locks, slot contents, fixed latencies.
  function automatic exp_t predict(input logic w, input logic lk, input logic [AW-1:0] s,
                                   input logic [W-1:0] d, input logic dead);
    exp_t e;
    int si;
    si = int'(s);
    e.write = w; e.slot = s; e.wdata = d; e.data = '0; e.err = 1'b0;
    e.lat = 0; e.acc = 0; e.rd = 0; e.wr = 0;
    if (si >= L) begin
      e.err = 1'b1; e.lat = 1;
    end else if (w && model_lock[si]) begin
      e.err = 1'b1; e.lat = 1;
    end else if (w) begin
      model_mem[si] = d;
      if (lk) model_lock[si] = 1'b1;
      e.lat = 2; e.wr = 1;
    end else if (dead) begin
      e.err = 1'b1; e.lat = 6; e.rd = 1;
    end else begin
      e.data = model_mem[si]; e.lat = 3; e.rd = 1;
    end
    e.lock = model_lock;
    return e;
  endfunction

  task automatic issue(input logic w, input logic lk, input logic [AW-1:0] s,
                       input logic [W-1:0] d, input logic dead, input int hold, input logic rnd);
    exp_t e;
    int   n;
    int   start;
    logic got;
    mem_dead = dead;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_lock = lk;
    bus.req_slot = s; bus.req_wdata = d;
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=0 for %0d cycles, want 1", n);
      bus.req_valid = 1'b0;
      return;
    end
    e = predict(w, lk, s, d, dead);
    e.acc = cyc;
    exp_q.push_back(e);
    start = done_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_wdata = {8{$urandom}}; bus.req_slot = AW'($urandom);
    n = 0;
    while (done_cnt == start && n < 60) begin
      if (bus.rsp_valid && hold > 0) begin
        bus.rsp_ready = 1'b0;
        hold--;
      end else begin
        bus.rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) begin
      total++; bad++;
      $display("FAIL rsp_timeout: no response handshake in %0d cycles, want one", n);
    end
    bus.rsp_ready = 1'b0;
  endtask

  // Start a read that never returns, then reset while it waits.
  task automatic reset_mid_wait();
    int   n;
    logic got;
    mem_dead = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_lock = 1'b0; bus.req_slot = '0;
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rst_accept_timeout: req_ready=0 for %0d cycles, want 1", n);
    end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2; rst = 1'b0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_lock_status", bus.lock_status, 0);
    chk("rst_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 0);
    @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    #1;
    chk("rst_release_ready", bus.req_ready, 1);
    model_lock = '0;
    mem_dead = 1'b0;
    bus.rsp_ready = 1'b0;
    $display("txn reset-mid-wait: abandoned read of slot 0");
  endtask

`ifdef KEY_FETCH_ZEROIZE_EN
  task automatic zeroize_test();
    int   n;
    int   waitc;
    logic started;
    logic gap;
    issue(1'b1, 1'b1, 3'd1, {8{$urandom}}, 1'b0, 0, 1'b0);
    issue(1'b1, 1'b1, 3'd3, {8{$urandom}}, 1'b0, 0, 1'b0);
    chk("pre_zero_locks", bus.lock_status & 6'b001010, 6'b001010);
    zmode = 1'b1;
    @(posedge clk); #1; zeroize = 1'b1;
    @(posedge clk); #1; zeroize = 1'b0;
    chk("zero_busy_on", zeroize_busy, 1);
    chk("zero_ready_off", bus.req_ready, 0);
    n = 0; waitc = 0; started = 1'b0; gap = 1'b0;
    while (n < L && waitc < 40) begin
      @(negedge clk);
      waitc++;
      chk("zero_rd_en", bus.mem_rd_en, 0);
      if (bus.mem_wr_en) begin
        chk("zero_addr", bus.mem_addr, n);
        chk("zero_wdata", bus.mem_wdata, 0);
        n++;
        started = 1'b1;
      end else if (started) begin
        gap = 1'b1;
      end
    end
    chk("zero_write_count", n, L);
    chk("zero_consecutive", gap, 0);
    @(negedge clk);
    chk("zero_busy_off", zeroize_busy, 0);
    chk("zero_locks_clear", bus.lock_status, 0);
    chk("zero_wr_after", bus.mem_wr_en, 0);
    for (int i = 0; i < L; i++) model_mem[i] = '0;
    model_lock = '0;
    zmode = 1'b0;
    $display("txn zeroize: %0d slots wiped", n);
    issue(1'b0, 1'b0, 3'd1, '0, 1'b0, 0, 1'b0);
  endtask
`endif

  // Monitor: pops one expectation per response and checks strobes and holding.
  initial begin : monitor
    exp_t         e;
    logic         in_rsp;
    int           rd_seen;
    int           wr_seen;
    int           stb_cyc;
    logic [AW-1:0] addr_seen;
    logic [W-1:0] wdata_seen;
    logic [W-1:0] held_data;
    logic         held_err;
    in_rsp = 1'b0; rd_seen = 0; wr_seen = 0; stb_cyc = 0;
    addr_seen = '0; wdata_seen = '0; held_data = '0; held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_rsp = 1'b0; rd_seen = 0; wr_seen = 0;
      end else begin
        if (!zmode) begin
          if (bus.mem_rd_en) rd_seen++;
          if (bus.mem_wr_en) wr_seen++;
          if (bus.mem_rd_en || bus.mem_wr_en) begin
            addr_seen = bus.mem_addr; wdata_seen = bus.mem_wdata; stb_cyc = cyc;
          end else begin
            chk("idle_addr", bus.mem_addr, 0);
            chk("idle_wdata", bus.mem_wdata, 0);
          end
        end
        if (bus.rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1'b1;
            held_data = bus.rsp_data;
            held_err = bus.rsp_err;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (no request pending)");
            end else begin
              e = exp_q.pop_front();
              chk("rsp_data", bus.rsp_data, e.data);
              chk("rsp_err", bus.rsp_err, e.err);
              chk("rsp_latency", cyc - e.acc, e.lat);
              chk("rd_strobes", rd_seen, e.rd);
              chk("wr_strobes", wr_seen, e.wr);
              if (e.rd + e.wr > 0) begin
                chk("strobe_addr", addr_seen, e.slot);
                chk("strobe_time", stb_cyc - e.acc, 1);
              end
              if (e.wr > 0) chk("strobe_wdata", wdata_seen, e.wdata);
              chk("lock_status", bus.lock_status, e.lock);
              $display("txn %s slot=%0d err=%0b lat=%0d data=%0h",
                       e.write ? "write" : "read ", e.slot, bus.rsp_err, cyc - e.acc, bus.rsp_data);
            end
          end else begin
            chk("hold_data", bus.rsp_data, held_data);
            chk("hold_err", bus.rsp_err, held_err);
          end
          chk("ready_in_rsp", bus.req_ready, 0);
          if (bus.rsp_ready) begin
            in_rsp = 1'b0; rd_seen = 0; wr_seen = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Stimulus: reset, directed scenarios, then randomized traffic.
  initial begin : stimulus
    logic          w;
    logic          lk;
    logic [AW-1:0] s;
    logic          dead;
    int            hold;
    cyc = 0; total = 0; bad = 0; done_cnt = 0;
    rst = 1'b1; mem_dead = 1'b0; preload = 1'b1; zmode = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_lock = 1'b0;
    bus.req_slot = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
`ifdef KEY_FETCH_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    for (int i = 0; i < L; i++) model_mem[i] = {8{$urandom}};
    model_mem[2] = 256'h988b6a57_0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_b8a93348;
    model_lock = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_lock_status", bus.lock_status, 0);
    rst = 1'b1;
    #1 chk("first_cycle_ready", bus.req_ready, 1);

    issue(1'b0, 1'b0, 3'd2, '0, 1'b0, 0, 1'b0);
    issue(1'b1, 1'b1, 3'd4, {32{8'hA5}}, 1'b0, 0, 1'b0);
    issue(1'b1, 1'b0, 3'd4, {32{8'h3C}}, 1'b0, 0, 1'b0);
    issue(1'b0, 1'b0, 3'd4, '0, 1'b0, 0, 1'b0);
    chk("lock_slot4_only", bus.lock_status, 6'b010000);
    issue(1'b0, 1'b0, 3'd7, '0, 1'b0, 0, 1'b0);
    issue(1'b0, 1'b0, 3'd1, '0, 1'b1, 5, 1'b0);
    reset_mid_wait();

    for (int k = 0; k < 80; k++) begin
      w    = ($urandom_range(0, 9) < 4);
      lk   = ($urandom_range(0, 9) < 2);
      s    = AW'($urandom_range(0, 7));
      dead = !w && ($urandom_range(0, 9) == 0);
      hold = $urandom_range(0, 3);
      issue(w, lk, s, {8{$urandom}}, dead, hold, 1'b1);
    end

`ifdef KEY_FETCH_ZEROIZE_EN
    zeroize_test();
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_fetch_ctrl.md
KEY_FETCH_CTRL -- requirements
Module: key_fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 256, key word width in bits.
REQ-002 SHALL have parameter LENGTH, default 6, number of key slots; AW = $clog2(LENGTH).
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when high together with req_valid.
REQ-007 req_write  in  1  1 = write slot, 0 = read slot.
REQ-008 req_lock  in  1  on a write, also lock the slot.
REQ-009 req_slot  in  AW  target slot index.
REQ-010 req_wdata  in  WIDTH  write data.
REQ-011 rsp_valid  out  1  response present; held until rsp_ready.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_data  out  WIDTH  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  request rejected or timed out.
REQ-015 mem_rd_en, mem_wr_en  out  1 each  key-store strobes.
REQ-016 mem_addr  out  AW; mem_wdata  out  WIDTH  key-store address and write data.
REQ-017 mem_rdata  in  WIDTH; mem_valid  in  1  key-store read return, registered one cycle after mem_rd_en.
REQ-018 lock_status  out  LENGTH  per-slot lock bits.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WAIT, RESP, plus ZERO when the REQ-034 feature is compiled in.
REQ-020 req_ready SHALL be 1 only in IDLE, and only when no zeroize is pending.
REQ-021 On acceptance (edge T), the FSM SHALL latch req_slot, req_write, req_lock and req_wdata.
REQ-022 Error case: slot >= LENGTH, or a write to a locked slot. The FSM SHALL go IDLE->RESP with no strobe, rsp_err=1, rsp_data=0, rsp_valid high in cycle T+1.
REQ-023 ACCESS SHALL last exactly one cycle, driving mem_addr=slot and exactly one strobe: mem_rd_en for reads, mem_wr_en with mem_wdata for writes.
REQ-024 Write: ACCESS->RESP, rsp_err=0, rsp_data=0. If req_lock=1, lock_status[slot] SHALL set on the ACCESS edge.
REQ-025 Read: ACCESS->WAIT. In WAIT, mem_rdata SHALL be captured on the cycle mem_valid=1, then go to RESP. Nominal rsp_valid is cycle T+3.
REQ-026 WAIT timeout: if mem_valid stays 0 for 4 consecutive WAIT cycles, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-027 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_valid&rsp_ready, then return to IDLE.
REQ-028 The FSM SHALL NOT accept a request in the same cycle a response handshakes (minimum 1 IDLE cycle).
REQ-029 Lock bits SHALL be sticky: set-only except for reset and zeroize. Reads of locked slots SHALL be permitted.
REQ-030 Strobes SHALL be 0 in every state except ACCESS and ZERO; mem_addr and mem_wdata SHALL be 0 when idle.

Reset
REQ-031 While rst=0: state=IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, strobes=0, mem_addr=0, mem_wdata=0, lock_status=0, timeout counter=0, zeroize pending=0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no response. Key-store contents are not affected by this block's reset.
REQ-033 After rst deasserts, req_ready SHALL be 1 in the first clock cycle.

Configuration
REQ-034 Macro KEY_FETCH_ZEROIZE_EN. When defined, the block SHALL add input zeroize (1) and output zeroize_busy (1), and:
- zeroize=1 in any state SHALL set a pending flag;
- in IDLE, pending SHALL take priority over req_valid and enter ZERO;
- ZERO SHALL write 0 to slots 0..LENGTH-1, one per cycle (LENGTH cycles, mem_wr_en=1), clear all lock_status, and clear pending;
- zeroize_busy=1 while pending or in ZERO;
- an in-flight transaction SHALL complete its RESP handshake first.
When undefined, the ports, the ZERO state and the pending flag SHALL be absent, and behaviour SHALL be as REQ-019..033.

Verification
REQ-035 Read slot 2, key store preloaded 0x988b6a57...b8a93348, rsp_ready=1 -> mem_rd_en one pulse at T+1, rsp_valid at T+3, rsp_data=0x988b6a57...b8a93348, rsp_err=0.
REQ-036 Write slot 4 data 0xA5..A5 with req_lock=1, then write slot 4 again, then read slot 4 -> lock_status=6'b010000; second write rsp_err=1 with no mem_wr_en; read returns 0xA5..A5.
REQ-037 Read slot 7 (LENGTH=6) -> no strobe, rsp_valid at T+1, rsp_err=1, rsp_data=0.
REQ-038 Read with mem_valid tied 0 -> rsp_err=1 after exactly 4 WAIT cycles; rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable throughout.
REQ-039 rst pulsed low during WAIT -> rsp_valid=0, lock_status=0, req_ready=1 in the first cycle after release.
REQ-040 With KEY_FETCH_ZEROIZE_EN, lock slots 1 and 3, then pulse zeroize -> 6 consecutive mem_wr_en with addr 0..5 and data 0, lock_status=0, zeroize_busy low after the last write, subsequent read of slot 1 returns 0.
